pulse_meas_sequencer: RTL and testbench

//  Round-robin scheduler sharing one pulse-width counter among N_CH pulse inputs.

---
 rtl/pulse_meas_sequencer_pkg.sv | 20 ++
 rtl/pulse_meas_sequencer_timer.sv | 29 ++
 rtl/pulse_meas_sequencer.sv | 154 +++++++++++++++
 tb/tb_pulse_meas_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meas_sequencer_pkg.sv
// Shared definitions for the pulse measurement sequencer: FSM encodings,
// default widths and the mux-select width helper.
package pulse_meas_sequencer_pkg;

    localparam int CW_DEF = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETTLE  = 3'd1;
    localparam state_t ST_DISCARD = 3'd2;
    localparam state_t ST_MEASURE = 3'd3;
    localparam state_t ST_REPORT  = 3'd4;
    localparam state_t ST_FINISH  = 3'd5;

    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_meas_sequencer_timer.sv
// Up-counter with synchronous clear and a terminal flag at a programmable
// limit; serves both the settle window and the per-channel timeout.
module meas_timeout_timer #(
    parameter int W = 8
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         term_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flag is raised in the last counted cycle of the window.
    assign term_o = en_i && (cnt_q == limit_i);

endmodule

// File: rtl/pulse_meas_sequencer.sv
// Round-robin sequencer that steers one shared pulse-width counter across
// N_CH inputs, dropping the first width after each switch.
module pulse_meas_sequencer
    import pulse_meas_sequencer_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int SETTLE_CYC  = 16,
    parameter  int TIMEOUT_CYC = 100000000,
    parameter  int CW          = CW_DEF,
    localparam int SEL_W       = sel_w(N_CH)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start_i,
    input  logic [N_CH-1:0]  chan_mask_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [SEL_W-1:0] sel_o,
    input  logic             cnt_valid_i,
    input  logic [CW-1:0]    cnt_width_i,
    output logic             res_wr_o,
    output logic [SEL_W-1:0] res_ch_o,
    output logic [CW-1:0]    res_width_o,
    output logic             res_tmo_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] SETTLE_LIM = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LIM    = TW'(TIMEOUT_CYC - 1);

    // Lowest set bit of m at index >= lo; MSB of the result is the found flag.
    function automatic logic [SEL_W:0] find_from(input logic [N_CH-1:0] m, input int lo);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) begin
                r = {1'b1, SEL_W'(i)};
            end
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  res_ch_q, res_ch_d;
    logic [CW-1:0]     res_width_q, res_width_d;
    logic              res_tmo_q, res_tmo_d;
    logic [SEL_W:0]    first_ch, next_ch;
    logic              tmr_clr, tmr_en, tmr_term;
    logic [TW-1:0]     tmr_limit;

    assign first_ch = find_from(chan_mask_i, 0);
    assign next_ch  = find_from(mask_q, int'(sel_q) + 1);

    assign tmr_en    = (state_q == ST_SETTLE) || (state_q == ST_DISCARD) || (state_q == ST_MEASURE);
    assign tmr_clr   = !tmr_en || ((state_q == ST_SETTLE) && tmr_term);
    assign tmr_limit = (state_q == ST_SETTLE) ? SETTLE_LIM : TMO_LIM;

    meas_timeout_timer #(.W(TW)) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .limit_i   (tmr_limit),
        .term_o    (tmr_term)
    );

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        sel_d       = sel_q;
        res_ch_d    = res_ch_q;
        res_width_d = res_width_q;
        res_tmo_d   = res_tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (first_ch[SEL_W]) begin
                        mask_d  = chan_mask_i;
                        sel_d   = first_ch[SEL_W-1:0];
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_term) state_d = ST_DISCARD;
            end
            ST_DISCARD: begin
                // No usable width can follow once the window is spent, so the timeout wins here.
                if (tmr_term) begin
                    state_d     = ST_REPORT;
                    res_ch_d    = sel_q;
                    res_width_d = '0;
                    res_tmo_d   = 1'b1;
                end else if (cnt_valid_i) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (cnt_valid_i) begin
                    state_d     = ST_REPORT;
                    res_ch_d    = sel_q;
                    res_width_d = cnt_width_i;
                    res_tmo_d   = 1'b0;
                end else if (tmr_term) begin
                    state_d     = ST_REPORT;
                    res_ch_d    = sel_q;
                    res_width_d = '0;
                    res_tmo_d   = 1'b1;
                end
            end
            ST_REPORT: begin
                if (next_ch[SEL_W]) begin
                    sel_d   = next_ch[SEL_W-1:0];
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            sel_q       <= '0;
            res_ch_q    <= '0;
            res_width_q <= '0;
            res_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            sel_q       <= sel_d;
            res_ch_q    <= res_ch_d;
            res_width_q <= res_width_d;
            res_tmo_q   <= res_tmo_d;
        end
    end

    assign busy_o      = tmr_en || (state_q == ST_REPORT);
    assign done_o      = (state_q == ST_FINISH);
    assign res_wr_o    = (state_q == ST_REPORT);
    assign sel_o       = sel_q;
    assign res_ch_o    = res_ch_q;
    assign res_width_o = res_width_q;
    assign res_tmo_o   = res_tmo_q;

endmodule

// File: tb/tb_pulse_meas_sequencer.sv
// Directed bench for the pulse measurement sequencer; a small counter model
// supplies per-channel widths, a monitor logs every result record.
module tb_pulse_meas_sequencer;

    localparam int N_CH    = 4;
    localparam int SETTLE  = 16;
    localparam int TMO     = 1000;
    localparam int GEN_PER = 200;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  chan_mask_i = '0;
    logic        busy_o, done_o, res_wr_o, res_tmo_o;
    logic [1:0]  sel_o, res_ch_o;
    logic        cnt_valid_i;
    logic [31:0] cnt_width_i, res_width_o;

    logic        gen_en = 1'b0, gen_valid = 1'b0, man_valid = 1'b0;
    logic [31:0] gen_width = '0, man_width = '0;
    logic [31:0] ch_hi [4];
    int          per_cnt = 0;

    int          cyc = 0, res_cnt = 0, done_cnt = 0, busy_rise_cyc = 0;
    logic        busy_prev = 1'b0;
    logic [31:0] log_ch [32], log_w [32], log_tmo [32], log_t [32];

    int nvec = 0, nerr = 0;
    int rb, dc;

    assign cnt_valid_i = gen_en ? gen_valid : man_valid;
    assign cnt_width_i = gen_en ? gen_width : man_width;

    always #5 sys_clk = ~sys_clk;

    pulse_meas_sequencer #(
        .N_CH(N_CH), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .CW(32)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start_i     (start_i),
        .chan_mask_i (chan_mask_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sel_o       (sel_o),
        .cnt_valid_i (cnt_valid_i),
        .cnt_width_i (cnt_width_i),
        .res_wr_o    (res_wr_o),
        .res_ch_o    (res_ch_o),
        .res_width_o (res_width_o),
        .res_tmo_o   (res_tmo_o)
    );

    // Shared counter model: one completed width every GEN_PER cycles on the selected input.
    always @(negedge sys_clk) begin
        if (!gen_en) begin
            per_cnt   = 0;
            gen_valid = 1'b0;
        end else if (per_cnt == GEN_PER - 1) begin
            per_cnt   = 0;
            gen_valid = (ch_hi[sel_o] != 0);
            gen_width = ch_hi[sel_o];
        end else begin
            per_cnt   = per_cnt + 1;
            gen_valid = 1'b0;
        end
    end

    always @(posedge sys_clk) begin
        #1;
        cyc = cyc + 1;
        if (res_wr_o && res_cnt < 32) begin
            log_ch[res_cnt]  = 32'(res_ch_o);
            log_w[res_cnt]   = res_width_o;
            log_tmo[res_cnt] = 32'(res_tmo_o);
            log_t[res_cnt]   = 32'(cyc);
            res_cnt = res_cnt + 1;
        end
        if (done_o) done_cnt = done_cnt + 1;
        if (busy_o && !busy_prev) busy_rise_cyc = cyc;
        busy_prev = busy_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec = nvec + 1;
        assert (obs === exp) else begin
            nerr = nerr + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0d expected=%0d", nvec, tag, obs, exp);
    endtask

    task automatic pulse_start(input logic [3:0] m);
        chan_mask_i = m;
        start_i     = 1'b1;
        @(negedge sys_clk);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done_o && k < 3000) begin
            @(negedge sys_clk);
            k = k + 1;
        end
        chk(tag, 32'(done_o), 32'd1);
        @(negedge sys_clk);
    endtask

    task automatic man_pulse(input logic [31:0] w);
        man_valid = 1'b1;
        man_width = w;
        @(negedge sys_clk);
        man_valid = 1'b0;
    endtask

    initial begin
        ch_hi[0] = 32'd50;
        ch_hi[1] = 32'd0;
        ch_hi[2] = 32'd120;
        ch_hi[3] = 32'd90;

        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_res_wr", 32'(res_wr_o), 32'd0);
        chk("rst_res_tmo", 32'(res_tmo_o), 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_res_ch", 32'(res_ch_o), 32'd0);
        chk("rst_res_width", res_width_o, 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Two-channel sweep.
        gen_en = 1'b1;
        rb = res_cnt; dc = done_cnt;
        pulse_start(4'b0101);
        chk("t1_busy_rise", 32'(busy_o), 32'd1);
        chk("t1_sel_first", 32'(sel_o), 32'd0);
        wait_done("t1_done");
        chk("t1_nres", 32'(res_cnt - rb), 32'd2);
        chk("t1_r0_ch", log_ch[rb], 32'd0);
        chk("t1_r0_w", log_w[rb], 32'd50);
        chk("t1_r0_tmo", log_tmo[rb], 32'd0);
        chk("t1_r1_ch", log_ch[rb+1], 32'd2);
        chk("t1_r1_w", log_w[rb+1], 32'd120);
        chk("t1_r1_tmo", log_tmo[rb+1], 32'd0);
        chk("t1_ndone", 32'(done_cnt - dc), 32'd1);
        chk("t1_busy_end", 32'(busy_o), 32'd0);
        chk("t1_sel_end", 32'(sel_o), 32'd2);

        // Timeout on a silent channel.
        rb = res_cnt;
        pulse_start(4'b0010);
        wait_done("t2_done");
        chk("t2_nres", 32'(res_cnt - rb), 32'd1);
        chk("t2_ch", log_ch[rb], 32'd1);
        chk("t2_w", log_w[rb], 32'd0);
        chk("t2_tmo", log_tmo[rb], 32'd1);
        chk("t2_latency", log_t[rb] - 32'(busy_rise_cyc), 32'(SETTLE + TMO));

        // Empty mask: done next cycle, nothing else.
        rb = res_cnt; dc = done_cnt;
        pulse_start(4'b0000);
        chk("t3_done", 32'(done_o), 32'd1);
        chk("t3_busy", 32'(busy_o), 32'd0);
        @(negedge sys_clk);
        chk("t3_done_drop", 32'(done_o), 32'd0);
        chk("t3_nres", 32'(res_cnt - rb), 32'd0);
        chk("t3_ndone", 32'(done_cnt - dc), 32'd1);

        // Start while busy is ignored.
        rb = res_cnt;
        pulse_start(4'b0001);
        repeat (3) @(negedge sys_clk);
        pulse_start(4'b1110);
        wait_done("t4_done");
        chk("t4_nres", 32'(res_cnt - rb), 32'd1);
        chk("t4_ch", log_ch[rb], 32'd0);
        chk("t4_w", log_w[rb], 32'd50);

        // Strobes during settle and the first after it are dropped.
        gen_en = 1'b0;
        rb = res_cnt;
        pulse_start(4'b1000);
        repeat (4) @(negedge sys_clk);
        man_pulse(32'd11);
        repeat (20) @(negedge sys_clk);
        man_pulse(32'd22);
        repeat (10) @(negedge sys_clk);
        man_pulse(32'd33);
        wait_done("t5_done");
        chk("t5_nres", 32'(res_cnt - rb), 32'd1);
        chk("t5_ch", log_ch[rb], 32'd3);
        chk("t5_w", log_w[rb], 32'd33);
        chk("t5_tmo", log_tmo[rb], 32'd0);

        // Asynchronous reset while measuring, then a clean sweep.
        pulse_start(4'b0100);
        repeat (20) @(negedge sys_clk);
        man_pulse(32'd77);
        repeat (5) @(negedge sys_clk);
        rb = res_cnt; dc = done_cnt;
        sys_rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_sel", 32'(sel_o), 32'd0);
        chk("t6_res_wr", 32'(res_wr_o), 32'd0);
        chk("t6_done", 32'(done_o), 32'd0);
        chk("t6_res_width", res_width_o, 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("t6_nres_rst", 32'(res_cnt - rb), 32'd0);
        chk("t6_ndone_rst", 32'(done_cnt - dc), 32'd0);
        gen_en = 1'b1;
        pulse_start(4'b0101);
        wait_done("t6_done2");
        chk("t6_nres", 32'(res_cnt - rb), 32'd2);
        chk("t6_r0_ch", log_ch[rb], 32'd0);
        chk("t6_r0_w", log_w[rb], 32'd50);
        chk("t6_r1_ch", log_ch[rb+1], 32'd2);
        chk("t6_r1_w", log_w[rb+1], 32'd120);
        chk("t6_ndone", 32'(done_cnt - dc), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
